// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: APB4 master that drives the SPI master's registers to run one
// 0x03 flash word read on CS0 and returns the RXFIFO word (or an error) to the requester.
module spi_flash_rd_seq #(
   parameter logic [7:0] CLK_DIV  = 8'd2,
   parameter logic [7:0] READ_CMD = 8'h03,
   parameter int         TIMEOUT  = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [23:0] req_addr_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic [11:0] paddr_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [31:0] pwdata_o,
   input  logic [31:0] prdata_i,
   input  logic        pready_i,
   input  logic        pslverr_i
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, AB_SETUP, AB_ACCESS, RESP} state_t;
   state_t        state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [23:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;
   logic          ab, sel, act, tmo;
   logic [11:0]   paddr;
   logic [31:0]   pwdata;
   assign ab  = state_q inside {AB_SETUP, AB_ACCESS};
   assign sel = ab || state_q inside {SETUP, ACCESS};
   assign act = state_q inside {ACCESS, AB_ACCESS};
   assign tmo = tmr_q == TW'(TIMEOUT - 1);
   // Register image for each step; the abort phase always issues the soft reset.
   always_comb begin
      paddr  = 12'h000;
      pwdata = 32'h0;
      if (ab) pwdata = 32'h0000_0010;
      else
         case (step_q)
            3'd0:    begin paddr = 12'h004; pwdata = {24'h0, CLK_DIV}; end
            3'd1:    begin paddr = 12'h008; pwdata = {READ_CMD, 24'h0}; end
            3'd2:    begin paddr = 12'h00C; pwdata = {addr_q, 8'h00}; end
            3'd3:    begin paddr = 12'h010; pwdata = 32'h0020_1808; end
            3'd4:    paddr = 12'h014;
            3'd5:    pwdata = 32'h0000_0101;
            default: paddr = 12'h020;
         endcase
   end
   assign psel_o      = sel;
   assign penable_o   = act;
   assign paddr_o     = sel ? paddr : 12'h0;
   assign pwrite_o    = sel && (ab || step_q != 3'd6);
   assign pwdata_o    = sel ? pwdata : 32'h0;
   assign req_ready_o = state_q == IDLE;
   assign rsp_valid_o = state_q == RESP;
   assign rsp_data_o  = data_q;
   assign rsp_err_o   = err_q;
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      tmr_d   = tmr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE:
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               step_d  = 3'd0;
               data_d  = 32'h0;
               err_d   = 1'b0;
               state_d = SETUP;
            end
         SETUP: begin
            tmr_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            tmr_d = tmr_q + 1'b1;
            if (pready_i && !pslverr_i) begin
               if (step_q == 3'd6) begin
                  data_d  = prdata_i;
                  state_d = RESP;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = SETUP;
               end
            end else if (pready_i || tmo) state_d = AB_SETUP;
         end
         AB_SETUP: begin
            tmr_d   = '0;
            state_d = AB_ACCESS;
         end
         AB_ACCESS: begin
            tmr_d = tmr_q + 1'b1;
            if (pready_i || tmo) begin
               data_d  = 32'h0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         step_q  <= 3'd0;
         tmr_q   <= '0;
         addr_q  <= 24'h0;
         data_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         tmr_q   <= tmr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: directed checks of the flash read sequencer against a small APB slave;
// a second instance with TIMEOUT=16 covers the timeout abort path.
module tb_spi_flash_rd_seq;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic        req_valid = 1'b0, rsp_ready = 1'b0, use16 = 1'b0;
   logic [23:0] req_addr = 24'h0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        rr0, rv0, re0, ps0, pe0, pw0, rr1, rv1, re1, ps1, pe1, pw1;
   logic [31:0] rd0, wd0, rd1, wd1;
   logic [11:0] pa0, pa1;
   spi_flash_rd_seq u_dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && !use16), .req_ready_o(rr0),
      .req_addr_i(req_addr), .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready), .rsp_data_o(rd0),
      .rsp_err_o(re0), .paddr_o(pa0), .psel_o(ps0), .penable_o(pe0), .pwrite_o(pw0),
      .pwdata_o(wd0), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr));
   spi_flash_rd_seq #(.TIMEOUT(16)) u_dut16 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && use16), .req_ready_o(rr1),
      .req_addr_i(req_addr), .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_data_o(rd1),
      .rsp_err_o(re1), .paddr_o(pa1), .psel_o(ps1), .penable_o(pe1), .pwrite_o(pw1),
      .pwdata_o(wd1), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr));
   logic        req_ready, rsp_valid, rsp_err, psel, penable, pwrite;
   logic [31:0] rsp_data, pwdata;
   logic [11:0] paddr;
   assign req_ready = use16 ? rr1 : rr0;
   assign rsp_valid = use16 ? rv1 : rv0;
   assign rsp_err   = use16 ? re1 : re0;
   assign rsp_data  = use16 ? rd1 : rd0;
   assign psel      = use16 ? ps1 : ps0;
   assign penable   = use16 ? pe1 : pe0;
   assign pwrite    = use16 ? pw1 : pw0;
   assign pwdata    = use16 ? wd1 : wd0;
   assign paddr     = use16 ? pa1 : pa0;
   logic [31:0] rx_data = 32'h0;
   int          rx_wait = 0, wcnt = 0, cyc = 0;
   bit          rx_never = 1'b0, err_en = 1'b0;
   logic [11:0] err_addr = 12'h0;
   assign pready  = psel && penable && (paddr != 12'h020 || (!rx_never && wcnt >= rx_wait));
   assign pslverr = pready && err_en && paddr == err_addr;
   assign prdata  = paddr == 12'h020 ? rx_data : 32'h0;
   logic [11:0] la[$];
   logic [31:0] ld[$];
   logic        lw[$];
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      wcnt <= (psel && penable && paddr == 12'h020 && !pready) ? wcnt + 1 : 0;
      if (psel && penable && pready) begin
         la.push_back(paddr);
         ld.push_back(pwdata);
         lw.push_back(pwrite);
      end
   end
   int pass_n = 0, tot = 0, t0 = 0, base = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot++;
      assert (obs === exp) pass_n++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   task automatic start_req(input logic [23:0] a);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      base      = la.size();
      t0        = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask
   task automatic wait_rsp(input string tag, input int exp_lat);
      int n = 0;
      while (!rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, cyc - t0, exp_lat);
   endtask
   task automatic finish_rsp(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_rsp_dropped"}, {30'h0, rsp_valid, req_ready}, 32'h1);
   endtask
   task automatic wait_apb(input logic [11:0] a);
      int n = 0;
      while (!(psel && penable && paddr == a) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("wait_apb_found", {20'h0, paddr}, {20'h0, a});
   endtask
   task automatic chk_seq(input string tag, input logic [23:0] a, input logic [31:0] rd);
      logic [11:0] ea[7];
      logic [31:0] ed[7];
      ea = '{12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h000, 12'h020};
      ed = '{32'h2, 32'h0300_0000, {a, 8'h00}, 32'h0020_1808, 32'h0, 32'h101, 32'h0};
      chk({tag, "_n_access"}, la.size() - base, 7);
      for (int i = 0; i < 7 && base + i < la.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), {20'h0, la[base+i]}, {20'h0, ea[i]});
         chk($sformatf("%s_wdata%0d", tag, i), ld[base+i], ed[i]);
         chk($sformatf("%s_write%0d", tag, i), {31'h0, lw[base+i]}, {31'h0, i != 6});
      end
      chk({tag, "_rsp_data"}, rsp_data, rd);
      chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
   endtask
   bit ok;
   logic [31:0] held;
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_outputs", {26'h0, rsp_valid, rsp_err, psel, penable, pwrite, |paddr}, 32'h0);
      chk("rst_data", rsp_data | pwdata, 32'h0);
      rst = 1'b0;
      // zero-wait read
      rx_data = 32'hDEAD_BEEF;
      start_req(24'h123456);
      chk("busy_req_ready", {31'h0, req_ready}, 32'h0);
      wait_rsp("zw", 15);
      chk_seq("zw", 24'h123456, 32'hDEAD_BEEF);
      finish_rsp("zw");
      // slow RXFIFO
      rx_data = 32'hCAFE_F00D;
      rx_wait = 40;
      start_req(24'hABCDEF);
      wait_apb(12'h020);
      ok = 1'b1;
      repeat (39) begin
         @(negedge clk);
         ok = ok && psel && penable && paddr == 12'h020 && !pwrite && pwdata == 32'h0 && !rsp_valid;
      end
      chk("slow_stable", {31'h0, ok}, 32'h1);
      wait_rsp("slow", 55);
      chk_seq("slow", 24'hABCDEF, 32'hCAFE_F00D);
      finish_rsp("slow");
      rx_wait = 0;
      // slave error on 0x0C
      err_en   = 1'b1;
      err_addr = 12'h00C;
      start_req(24'h000777);
      wait_rsp("serr", 9);
      chk("serr_n_access", la.size() - base, 4);
      if (la.size() - base == 4) begin
         chk("serr_abort_addr", {20'h0, la[base+3]}, 32'h0);
         chk("serr_abort_data", ld[base+3], 32'h10);
         chk("serr_abort_write", {31'h0, lw[base+3]}, 32'h1);
      end
      chk("serr_err", {31'h0, rsp_err}, 32'h1);
      chk("serr_data", rsp_data, 32'h0);
      finish_rsp("serr");
      err_en = 1'b0;
      // RXFIFO never ready, TIMEOUT=16
      use16    = 1'b1;
      rx_never = 1'b1;
      start_req(24'h00BEEF);
      wait_rsp("tmo", 32);
      chk("tmo_n_access", la.size() - base, 7);
      if (la.size() - base == 7) begin
         chk("tmo_abort_addr", {20'h0, la[base+6]}, 32'h0);
         chk("tmo_abort_data", ld[base+6], 32'h10);
      end
      chk("tmo_err", {31'h0, rsp_err}, 32'h1);
      chk("tmo_data", rsp_data, 32'h0);
      finish_rsp("tmo");
      use16    = 1'b0;
      rx_never = 1'b0;
      // response back-pressure with a pending request
      rx_data = 32'h1357_9BDF;
      start_req(24'h111111);
      wait_rsp("bp", 15);
      req_valid = 1'b1;
      req_addr  = 24'h222222;
      held = rsp_data;
      ok   = 1'b1;
      repeat (10) begin
         @(negedge clk);
         ok = ok && rsp_valid && !req_ready && rsp_data == held && !rsp_err && !psel;
      end
      chk("bp_held", {31'h0, ok}, 32'h1);
      chk("bp_data", held, 32'h1357_9BDF);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle_after_hs", {30'h0, rsp_valid, req_ready}, 32'h1);
      base = la.size();
      t0   = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_accepted", {30'h0, req_ready, psel}, 32'h1);
      wait_rsp("bp2", 15);
      chk_seq("bp2", 24'h222222, 32'h1357_9BDF);
      finish_rsp("bp2");
      // reset during step 3 access
      start_req(24'h333333);
      wait_apb(12'h010);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_apb", {30'h0, psel, penable}, 32'h0);
      chk("mrst_hs", {30'h0, req_ready, rsp_valid}, 32'h2);
      rst = 1'b0;
      rx_data = 32'h0BAD_CAFE;
      start_req(24'h444444);
      wait_rsp("clean", 15);
      chk_seq("clean", 24'h444444, 32'h0BAD_CAFE);
      finish_rsp("clean");
      $display("%0d/%0d checks passed", pass_n, tot);
      $finish;
   end
endmodule
